// File: rtl/pb_event_arbiter.sv
// Push-button front end: per-button synchronizer and debounce, release-event latching,
// and a round-robin valid/ready command arbiter. Define PB_PRESS_EVT_EN to also issue press events.
module pb_event_arbiter #(
  parameter int NUM_PB    = 4,
  parameter int DB_CYCLES = 16,
  parameter int ID_W      = $clog2(NUM_PB)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_PB-1:0] PB,
  input  logic              cmd_rdy,
  input  logic              ovr_clr,
  output logic              cmd_vld,
  output logic [ID_W-1:0]   cmd_id,
  output logic              cmd_press,
  output logic [NUM_PB-1:0] pending,
  output logic [NUM_PB-1:0] overrun
);

  localparam int CNT_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

  typedef enum logic {IDLE, GRANT} state_t;
  state_t r_state, w_state_nxt;

  logic [NUM_PB-1:0] r_s1, r_s2, r_db, r_pend, r_ovr;
  logic [CNT_W-1:0]  r_cnt [NUM_PB];
  logic [NUM_PB-1:0] w_done, w_rise, w_clr_rel, w_set_ovr, w_ovr_set, w_elig;
  logic [ID_W-1:0]   r_cmd_id, r_ptr, w_sel, w_idx;
  logic              w_found, w_hs, w_srv_press;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1 <= '1;
      r_s2 <= '1;
    end else begin
      r_s1 <= PB;
      r_s2 <= r_s1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_db <= '1;
      for (int unsigned i = 0; i < NUM_PB; i++) r_cnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_PB; i++) begin
        if (r_s2[i] == r_db[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == CNT_MAX) begin
          r_db[i]  <= r_s2[i];
          r_cnt[i] <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + 1'b1;
        end
      end
    end
  end

  // Debounced edges are decoded from the counter so pending sets on the same edge db changes.
  always_comb begin
    w_done = '0;
    for (int unsigned i = 0; i < NUM_PB; i++)
      w_done[i] = (r_s2[i] != r_db[i]) && (r_cnt[i] == CNT_MAX);
  end
  assign w_rise = w_done & r_s2;

  assign w_hs = (r_state == GRANT) && cmd_rdy;

  always_comb begin
    w_clr_rel = '0;
    w_set_ovr = '0;
    for (int unsigned i = 0; i < NUM_PB; i++) begin
      w_clr_rel[i] = w_hs && (r_cmd_id == ID_W'(i)) && !w_srv_press;
      w_set_ovr[i] = w_rise[i] && r_pend[i] && !w_clr_rel[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_PB; i++) begin
        if (w_rise[i])         r_pend[i] <= 1'b1;
        else if (w_clr_rel[i]) r_pend[i] <= 1'b0;
      end
    end
  end

`ifdef PB_PRESS_EVT_EN
  logic [NUM_PB-1:0] r_ppend, w_fall, w_clr_prs, w_pset_ovr;
  logic              r_cmd_press;

  assign w_fall = w_done & ~r_s2;

  always_comb begin
    w_clr_prs  = '0;
    w_pset_ovr = '0;
    for (int unsigned i = 0; i < NUM_PB; i++) begin
      w_clr_prs[i]  = w_hs && (r_cmd_id == ID_W'(i)) && r_cmd_press;
      w_pset_ovr[i] = w_fall[i] && r_ppend[i] && !w_clr_prs[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ppend <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_PB; i++) begin
        if (w_fall[i])         r_ppend[i] <= 1'b1;
        else if (w_clr_prs[i]) r_ppend[i] <= 1'b0;
      end
    end
  end

  // Press is served ahead of release when both are pending on the selected button.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          r_cmd_press <= 1'b0;
    else if (r_state == IDLE && w_found) r_cmd_press <= r_ppend[w_sel];
  end

  assign w_elig      = r_pend | r_ppend;
  assign w_ovr_set   = w_set_ovr | w_pset_ovr;
  assign w_srv_press = r_cmd_press;
  assign cmd_press   = r_cmd_press;
`else
  assign w_elig      = r_pend;
  assign w_ovr_set   = w_set_ovr;
  assign w_srv_press = 1'b0;
  assign cmd_press   = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovr <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_PB; i++) begin
        if (w_ovr_set[i]) r_ovr[i] <= 1'b1;
        else if (ovr_clr) r_ovr[i] <= 1'b0;
      end
    end
  end

  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    w_idx   = '0;
    for (int unsigned k = 0; k < NUM_PB; k++) begin
      w_idx = ID_W'((32'(r_ptr) + k) % 32'(NUM_PB));
      if (!w_found && w_elig[w_idx]) begin
        w_found = 1'b1;
        w_sel   = w_idx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_found) w_state_nxt = GRANT;
      GRANT:   if (cmd_rdy) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cmd_vld = (r_state == GRANT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cmd_id <= '0;
      r_ptr    <= '0;
    end else if (r_state == IDLE && w_found) begin
      r_cmd_id <= w_sel;
    end else if (w_hs) begin
      r_ptr <= (r_cmd_id == ID_W'(NUM_PB - 1)) ? '0 : r_cmd_id + 1'b1;
    end
  end

  assign cmd_id  = r_cmd_id;
  assign pending = r_pend;
  assign overrun = r_ovr;

endmodule

// File: tb/tb_pb_event_arbiter.sv
// Directed bench for pb_event_arbiter (NUM_PB=4, DB_CYCLES=4); expectations adapt to PB_PRESS_EVT_EN.
module tb_pb_event_arbiter;

`ifdef PB_PRESS_EVT_EN
  localparam int PRESS = 1;
`else
  localparam int PRESS = 0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [3:0] PB = 4'hF;
  logic       cmd_rdy = 1'b0;
  logic       ovr_clr = 1'b0;
  logic       cmd_vld;
  logic [1:0] cmd_id;
  logic       cmd_press;
  logic [3:0] pending;
  logic [3:0] overrun;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  int unsigned vld_pulses = 0;
  logic        prev_vld = 1'b0;
  logic        flag;
  logic [2:0]  hs_q[$];

  always #5 clk = ~clk;

  pb_event_arbiter #(.NUM_PB(4), .DB_CYCLES(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .PB        (PB),
    .cmd_rdy   (cmd_rdy),
    .ovr_clr   (ovr_clr),
    .cmd_vld   (cmd_vld),
    .cmd_id    (cmd_id),
    .cmd_press (cmd_press),
    .pending   (pending),
    .overrun   (overrun)
  );

  // Handshakes recorded as {press, id}; inputs only move just after posedge.
  always @(negedge clk) begin
    if (rst_n && cmd_vld && cmd_rdy) hs_q.push_back({cmd_press, cmd_id});
    if (rst_n && cmd_vld && !prev_vld) vld_pulses++;
    prev_vld = cmd_vld;
  end

  task automatic step(input int unsigned n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state
    #3 rst_n = 1'b0;
    #1;
    check("rst_vld", cmd_vld, 0);
    check("rst_id", cmd_id, 0);
    check("rst_press", cmd_press, 0);
    check("rst_pend", pending, 0);
    check("rst_ovr", overrun, 0);
    step(3);
    rst_n = 1'b1;
    step(50);
    check("idle_pulses", vld_pulses, 0);
    check("idle_pend", pending, 0);

    // Single release of button 2
    cmd_rdy = 1'b1;
    hs_q.delete();
    vld_pulses = 0;
    PB[2] = 1'b0;
    step(10);
    check("p2_pend", pending, 0);
    check("p2_hs", hs_q.size(), PRESS);
    hs_q.delete();
    vld_pulses = 0;
    PB[2] = 1'b1;
    flag = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step(1);
      flag = flag | cmd_vld;
    end
    check("r2_early", flag, 0);
    check("r2_pend6", pending, 4'b0100);
    step(1);
    check("r2_vld7", cmd_vld, 1);
    check("r2_id", cmd_id, 2);
    check("r2_press", cmd_press, 0);
    step(1);
    check("r2_vld8", cmd_vld, 0);
    check("r2_pend8", pending, 0);
    step(8);
    check("r2_pulses", vld_pulses, 1);
    check("r2_hs", hs_q.size(), 1);

    // Bounce rejection on button 1
    hs_q.delete();
    PB[1] = 1'b0;
    step(10);
    check("b_press_hs", hs_q.size(), PRESS);
    hs_q.delete();
    vld_pulses = 0;
    for (int i = 0; i < 10; i++) begin
      PB[1] = (i % 2 == 0);
      step(2);
    end
    check("b_pulses", vld_pulses, 0);
    check("b_pend", pending, 0);
    PB[1] = 1'b1;
    step(12);
    check("b_hs_n", hs_q.size(), 1);
    if (hs_q.size() >= 1) check("b_hs0", hs_q[0], 3'b001);

    // Round-robin from pointer 0 over pending 1011
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
    cmd_rdy = 1'b1;
    PB = 4'b0100;
    step(14);
    hs_q.delete();
    cmd_rdy = 1'b0;
    PB = 4'hF;
    step(6);
    check("rr_pend", pending, 4'b1011);
    check("rr_vld6", cmd_vld, 0);
    step(1);
    check("rr_vld7", cmd_vld, 1);
    check("rr_id0", cmd_id, 0);
    step(2);
    check("rr_hold_vld", cmd_vld, 1);
    check("rr_hold_id", cmd_id, 0);
    cmd_rdy = 1'b1;
    step(1);
    check("rr_bub1", cmd_vld, 0);
    step(1);
    check("rr_vld_b", cmd_vld, 1);
    check("rr_id1", cmd_id, 1);
    step(1);
    check("rr_bub2", cmd_vld, 0);
    step(1);
    check("rr_vld_c", cmd_vld, 1);
    check("rr_id3", cmd_id, 3);
    step(1);
    check("rr_end_vld", cmd_vld, 0);
    check("rr_end_pend", pending, 0);
    check("rr_hs_n", hs_q.size(), 3);
    if (hs_q.size() == 3) begin
      check("rr_hs0", hs_q[0], 3'b000);
      check("rr_hs1", hs_q[1], 3'b001);
      check("rr_hs2", hs_q[2], 3'b011);
    end

    // Stall with a double release on button 0
    cmd_rdy = 1'b0;
    hs_q.delete();
    vld_pulses = 0;
    PB[0] = 1'b0;
    step(8);
    PB[0] = 1'b1;
    step(8);
    check("ov_first", overrun, 0);
    check("ov_vld", cmd_vld, 1);
    check("ov_id", cmd_id, 0);
    check("ov_press", cmd_press, PRESS);
    check("ov_pend1", pending, 4'b0001);
    flag = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (i == 0) PB[0] = 1'b0;
      if (i == 8) PB[0] = 1'b1;
      step(1);
      if (!(cmd_vld === 1'b1 && cmd_id === 2'd0 && cmd_press === 1'(PRESS))) flag = 1'b1;
    end
    check("ov_hold", flag, 0);
    check("ov_set", overrun, 4'b0001);
    check("ov_pend2", pending, 4'b0001);
    check("ov_pulses", vld_pulses, 1);
    check("ov_hs", hs_q.size(), 0);
    ovr_clr = 1'b1;
    step(1);
    ovr_clr = 1'b0;
    check("ov_clr", overrun, 0);
    check("ov_clr_vld", cmd_vld, 1);

    // Asynchronous reset in the middle of GRANT
    #2 rst_n = 1'b0;
    #1;
    check("mr_vld", cmd_vld, 0);
    check("mr_id", cmd_id, 0);
    check("mr_press", cmd_press, 0);
    check("mr_pend", pending, 0);
    check("mr_ovr", overrun, 0);
    step(1);
    rst_n = 1'b1;
    cmd_rdy = 1'b1;
    hs_q.delete();
    step(20);
    check("mr_dropped", hs_q.size(), 0);

    // Press then release of button 3
    hs_q.delete();
    PB[3] = 1'b0;
    step(10);
    PB[3] = 1'b1;
    step(10);
    check("p3_hs_n", hs_q.size(), 1 + PRESS);
    if (hs_q.size() == 1 + PRESS) begin
`ifdef PB_PRESS_EVT_EN
      check("p3_press_cmd", hs_q[0], 3'b111);
`endif
      check("p3_rel_cmd", hs_q[PRESS], 3'b011);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pb_event_arbiter.md
Name: pb_event_arbiter

Overview:
- Front-end controller for up to NUM_PB mechanical push buttons (idle high, pressed low) that share one downstream command consumer, e.g. the up/down counter.
- Each button has its own 2-flop synchronizer and debounce filter. Debounced release events (0->1) are latched as pending.
- A round-robin arbiter issues one command at a time over a valid/ready handshake.
- Sits between the board pins and the counter/control datapath.

Parameters:
- NUM_PB, 4, number of buttons (2..8).
- DB_CYCLES, 16, consecutive stable synchronized cycles required before the debounced state changes (>=1).
- ID_W, $clog2(NUM_PB), width of cmd_id.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset, asynchronous, active-low.
- PB  input  NUM_PB  raw asynchronous buttons; 1 = released, 0 = pressed.
- cmd_rdy  input  1  consumer accepts the current command.
- ovr_clr  input  1  synchronous clear of the overrun flags.
- cmd_vld  output  1  command valid.
- cmd_id  output  ID_W  button index of the command.
- cmd_press  output  1  1 = press event, 0 = release event.
- pending  output  NUM_PB  per-button release-pending bits.
- overrun  output  NUM_PB  sticky: an event was lost on that button.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - Synchronizer flops and debounced state preset to 1.
  - Debounce counters = 0; pending = 0; overrun = 0; RR pointer = 0.
  - FSM = IDLE; cmd_vld = 0; cmd_id = 0; cmd_press = 0.
- Synchronizer: s1 <= PB, s2 <= s1, per bit. Only s2 is used downstream.
- Debounce, per button:
  - If s2 == db: cnt <= 0.
  - Else if cnt == DB_CYCLES-1: db <= s2, cnt <= 0.
  - Else cnt++.
  - Any glitch back to db restarts the count.
- Release event: the edge on which db goes 0->1 sets pending[i] on that same edge.
- Latency: with the FSM idle, PB rising (first sampled high at edge 1) gives db/pending updated at edge DB_CYCLES+2 and cmd_vld high after edge DB_CYCLES+3.
- FSM states:
  - IDLE:
    - cmd_vld = 0.
    - If any pending bit is set: select the first set bit at or after the RR pointer (wrapping), latch it into cmd_id, go to GRANT.
  - GRANT:
    - cmd_vld = 1; cmd_id/cmd_press held stable.
    - On cmd_rdy=1: clear that pending bit, set RR pointer to cmd_id+1 (wrap at NUM_PB-1 -> 0), go to IDLE.
    - Back-to-back commands therefore have one idle bubble cycle.
- cmd_rdy while in IDLE is ignored.
- Overrun:
  - A new release on button i while pending[i]=1 and pending[i] is not being cleared on that edge sets overrun[i]. pending stays 1 (events coalesce).
  - Release on button i on the same edge its command handshakes: pending[i] stays 1 and no overrun is raised.
  - ovr_clr clears all overrun bits. If a set and ovr_clr coincide, set wins.
- Press transitions (db 1->0) generate no command unless the optional feature is enabled.
- cmd_id is latched in IDLE->GRANT and never changes during GRANT, even if higher-priority pending bits appear.
- Reset mid-GRANT: the command is dropped and all pending is lost.

Optional Feature:
- Macro: PB_PRESS_EVT_EN.
- With the macro defined:
  - Per-button press_pending bit, set on db 1->0, with overrun handling identical to release.
  - Arbitration stays round-robin over buttons. A button is eligible if either bit is set; within a button, press is served before release.
  - cmd_press = 1 for press commands. The handshake clears only the served bit.
- Without the macro: press_pending logic is absent and cmd_press is tied 0.

Test Plan:
- Bench uses NUM_PB=4, DB_CYCLES=4.
- Reset check: assert rst_n=0 mid-cycle -> all outputs 0 immediately. Hold all PB=1 for 50 cycles -> cmd_vld stays 0.
- Single release: PB[2] 1->0, held 10 cycles, then 0->1 with cmd_rdy=1 -> exactly one cmd_vld pulse with cmd_id=2, cmd_press=0, first high after edge 7 following the release.
- Bounce rejection: PB[1] toggles every 2 cycles for 20 cycles, then settles at 1 -> exactly one release command id=1, none during bouncing.
- Round-robin: pending=4'b1011 with the pointer at 0 and cmd_rdy=1 -> ids issued 0,1,3, each separated by one idle cycle.
- Stall and overrun: cmd_rdy=0 while button 0 releases twice -> overrun[0]=1, a single id=0 command held stable during GRANT. ovr_clr pulse -> overrun=0.
- PB_PRESS_EVT_EN defined: press then release of PB[3] with cmd_rdy=1 -> two commands: id=3 with cmd_press=1, then id=3 with cmd_press=0.
